// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage A holds the accepted request; stage B holds the computed result and flags.
module alu_pipe #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags,
  output logic         err,
  input  logic         clr_err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_LSH  = 4'd6;
  localparam logic [3:0] OP_RSH  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SEQ  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_SLTU = 4'd13;

  logic         va_q, va_d;
  logic [3:0]   op_a_q, op_a_d;
  logic [W-1:0] a_a_q, a_a_d, b_a_q, b_a_d;
  logic         vb_q, vb_d;
  logic [W-1:0] res_q, res_d;
  logic [3:0]   flags_q, flags_d;
  logic         ill_q, ill_d;
  logic         err_q, err_d;
  logic         ready_b;

  logic [SW-1:0]  sh;
  logic [W:0]     add_w, sub_w, shl_w, shr_w, asr_w;
  logic [2*W-1:0] rol_w, ror_w;
  logic [W-1:0]   alu_res;
  logic           alu_c, alu_v, alu_ill;

  assign ready_b   = !vb_q || out_ready;
  assign in_ready  = !va_q || ready_b;
  assign out_valid = vb_q;
  assign result    = res_q;
  assign flags     = flags_q;
  assign err       = err_q;

  // Shifts are done one bit wider so the last bit shifted out lands in the extra bit.
  always_comb begin
    sh      = b_a_q[SW-1:0];
    add_w   = {1'b0, a_a_q} + {1'b0, b_a_q};
    sub_w   = {1'b0, a_a_q} + {1'b0, ~b_a_q} + (W+1)'(1);
    shl_w   = {1'b0, a_a_q} << sh;
    shr_w   = {a_a_q, 1'b0} >> sh;
    asr_w   = $unsigned($signed({a_a_q, 1'b0}) >>> sh);
    rol_w   = {a_a_q, a_a_q} << sh;
    ror_w   = {a_a_q, a_a_q} >> sh;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op_a_q)
      OP_ADD: begin
        alu_res = add_w[W-1:0];
        alu_c   = add_w[W];
        alu_v   = (a_a_q[W-1] == b_a_q[W-1]) && (add_w[W-1] != a_a_q[W-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[W-1:0];
        alu_c   = sub_w[W];
        alu_v   = (a_a_q[W-1] != b_a_q[W-1]) && (sub_w[W-1] != a_a_q[W-1]);
      end
      OP_AND:  alu_res = a_a_q & b_a_q;
      OP_OR:   alu_res = a_a_q | b_a_q;
      OP_XOR:  alu_res = a_a_q ^ b_a_q;
      OP_NOT:  alu_res = ~a_a_q;
      OP_LSH: begin
        alu_res = shl_w[W-1:0];
        alu_c   = shl_w[W];
      end
      OP_RSH: begin
        alu_res = shr_w[W:1];
        alu_c   = shr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[W:1];
        alu_c   = asr_w[0];
      end
      OP_SLT:  alu_res = {{(W-1){1'b0}}, $signed(a_a_q) < $signed(b_a_q)};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, a_a_q < b_a_q};
      OP_SEQ:  alu_res = {{(W-1){1'b0}}, a_a_q == b_a_q};
      OP_ROL:  alu_res = rol_w[2*W-1:W];
      OP_ROR:  alu_res = ror_w[W-1:0];
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    va_d    = va_q;
    op_a_d  = op_a_q;
    a_a_d   = a_a_q;
    b_a_d   = b_a_q;
    vb_d    = vb_q;
    res_d   = res_q;
    flags_d = flags_q;
    ill_d   = ill_q;
    err_d   = err_q;
    if (in_ready) begin
      va_d = in_valid;
      if (in_valid) begin
        op_a_d = op;
        a_a_d  = a;
        b_a_d  = b;
      end
    end
    if (ready_b) begin
      vb_d = va_q;
      if (va_q) begin
        res_d   = alu_res;
        flags_d = {alu_res[W-1], alu_res == '0, alu_c, alu_v};
        ill_d   = alu_ill;
      end
    end
    // An illegal-op transfer takes priority over a simultaneous clear.
    if (clr_err) err_d = 1'b0;
    if (vb_q && out_ready && ill_q) err_d = 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      va_q    <= 1'b0;
      op_a_q  <= '0;
      a_a_q   <= '0;
      b_a_q   <= '0;
      vb_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      va_q    <= va_d;
      op_a_q  <= op_a_d;
      a_a_q   <= a_a_d;
      b_a_q   <= b_a_d;
      vb_q    <= vb_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, stall, illegal-op, reset and random traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, err, clr_err;
  logic [3:0]   op, flags;
  logic [W-1:0] a, b, result;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  exp_t exp_q[$];

  alu_pipe #(.W(W)) dut (
    .Clk(clk), .Reset(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags),
    .err(err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(int o, int ia, int ib);
    exp_t e;
    int sa, sb, sh, r, c, v;
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    sh = ib % 8;
    r = 0; c = 0; v = 0;
    case (o)
      0:  begin r = (ia + ib) & 255; c = (ia + ib) >= 256 ? 1 : 0;
                v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0; end
      1:  begin r = (ia - ib) & 255; c = (ia >= ib) ? 1 : 0;
                v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0; end
      2:  r = ia & ib;
      3:  r = ia | ib;
      4:  r = ia ^ ib;
      5:  r = (~ia) & 255;
      6:  begin r = (ia << sh) & 255; c = (sh > 0) ? (ia >> (8 - sh)) & 1 : 0; end
      7:  begin r = ia >> sh; c = (sh > 0) ? (ia >> (sh - 1)) & 1 : 0; end
      8:  r = (sa < sb) ? 1 : 0;
      9:  r = (ia == ib) ? 1 : 0;
      10: begin r = (sa >>> sh) & 255; c = (sh > 0) ? (sa >>> (sh - 1)) & 1 : 0; end
      11: r = ((ia << sh) | (ia >> (8 - sh))) & 255;
      12: r = ((ia >> sh) | (ia << (8 - sh))) & 255;
      13: r = (ia < ib) ? 1 : 0;
      default: r = 0;
    endcase
    e.r = r[W-1:0];
    e.f = {e.r[W-1], e.r == 0, c[0], v[0]};
    return e;
  endfunction

  // Scoreboard: record accepts, compare every transfer out in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_unexpected: got result=%h flags=%b with nothing outstanding", result, flags);
        end else begin
          e = exp_q.pop_front();
          if (result !== e.r || flags !== e.f) begin
            n_fail++;
            $display("FAIL scoreboard: got result=%h flags=%b, want result=%h flags=%b", result, flags, e.r, e.f);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(op), int'(a), int'(b)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input int o, input int ia, input int ib);
    logic acc;
    op = o[3:0]; a = ia[W-1:0]; b = ib[W-1:0]; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: op=%0d never accepted", o);
    end
  endtask

  task automatic wait_out(input string name);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: out_valid=%b want 1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    op = '0; a = '0; b = '0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || flags !== 4'b0000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b result=%h flags=%b err=%b want 0 1 00 0000 0",
               out_valid, in_ready, result, flags, err);
    end
    @(posedge clk); #1; rst = 1'b0;
    step();
  endtask

  task automatic test_vectors();
    int vop[9]   = '{0, 1, 1, 10, 12, 8, 13, 6, 7};
    int va[9]    = '{8'h7F, 8'h03, 8'h05, 8'h90, 8'h01, 8'hFF, 8'hFF, 8'h80, 8'h01};
    int vb[9]    = '{8'h01, 8'h05, 8'h05, 8'h03, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    int vr[9]    = '{8'h80, 8'hFE, 8'h00, 8'hF2, 8'h80, 8'h01, 8'h00, 8'h00, 8'h01};
    int vf[9]    = '{4'b1001, 4'b1000, 4'b0110, 4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b0110, 4'b0000};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(vop[i], va[i], vb[i]);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_early_%0d: out_valid=%b one cycle after accept, want 0", i, out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || result !== vr[i][W-1:0] || flags !== vf[i][3:0]) begin
        n_fail++;
        $display("FAIL vector_%0d: out_valid=%b result=%h flags=%b want 1 %h %b",
                 i, out_valid, result, flags, vr[i][W-1:0], vf[i][3:0]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int   o[4], x[4], y[4];
    int   start;
    exp_t first;
    for (int i = 0; i < 4; i++) begin
      o[i] = $urandom_range(0, 13); x[i] = $urandom_range(0, 255); y[i] = $urandom_range(0, 255);
    end
    first = model(o[0], x[0], y[0]);
    start = n_out;
    out_ready = 1'b0;
    send(o[0], x[0], y[0]);
    send(o[1], x[1], y[1]);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full: in_ready=%b after two accepts with out_ready=0, want 0", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || result !== first.r || flags !== first.f || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: out_valid=%b result=%h flags=%b in_ready=%b want 1 %h %b 0",
                 c, out_valid, result, flags, in_ready, first.r, first.f);
      end
      step();
    end
    out_ready = 1'b1;
    send(o[2], x[2], y[2]);
    send(o[3], x[3], y[3]);
    for (int i = 0; i < 20 && n_out < start + 4; i++) step();
    n_checks++;
    if (n_out - start !== 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: outputs=%0d outstanding=%0d want 4 0", n_out - start, exp_q.size());
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    clr_err = 1'b1; step(); clr_err = 1'b0;
    send(14, $urandom_range(0, 255), $urandom_range(0, 255));
    wait_out("illegal14");
    n_checks++;
    if (result !== '0 || flags !== 4'b0100 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_result: result=%h flags=%b err=%b want 00 0100 0", result, flags, err);
    end
    step();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err_set: err=%b want 1", err);
    end
    repeat (3) step();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err_sticky: err=%b want 1", err);
    end
    send(15, $urandom_range(0, 255), $urandom_range(0, 255));
    wait_out("illegal15");
    clr_err = 1'b1; step(); clr_err = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_set_wins: err=%b want 1", err);
    end
    clr_err = 1'b1; step(); clr_err = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: err=%b want 0", err);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    out_ready = 1'b0;
    send($urandom_range(0, 13), $urandom_range(0, 255), $urandom_range(0, 255));
    send($urandom_range(0, 13), $urandom_range(0, 255), $urandom_range(0, 255));
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: out_valid=%b right after Reset, want 0", out_valid);
    end
    @(posedge clk); #1; rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || result !== '0 || flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b result=%h flags=%b want 1 00 0000", in_ready, result, flags);
    end
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      step();
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_stale: %0d stale outputs after Reset, want 0", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom_range(0, 255));
      b  = W'($urandom_range(0, 255));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand/result width (legal 4..32, power of two).
REQ-002 SHALL have parameter SW, default $clog2(W), meaning shift-amount width taken from low bits of b.
REQ-003 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle when in_valid also high.
REQ-007 SHALL have port op  input  4  operation code.
REQ-008 SHALL have port a, b  input  W each  operands.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle when out_valid also high.
REQ-011 SHALL have port result  output  W  operation result.
REQ-012 SHALL have port flags  output  4  {N,Z,C,V} for result.
REQ-013 SHALL have port err  output  1  sticky illegal-op status.
REQ-014 SHALL have port clr_err  input  1  clears err.

Function
REQ-015 SHALL decode op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 LSH, 7 RSH, 8 SLT, 9 SEQ, 10 ASR, 11 ROL, 12 ROR, 13 SLTU; 14-15 illegal.
REQ-016 SHALL compute: ADD a+b mod 2^W; SUB a+~b+1 mod 2^W; NOT ~a (b ignored); LSH/RSH logical by b[SW-1:0]; ASR sign-filling; ROL/ROR rotate by b[SW-1:0]; SLT 1 if signed a<b else 0; SLTU unsigned; SEQ 1 if a==b else 0 (zero-extended to W).
REQ-017 SHALL set N=result[W-1], Z=(result==0) for all ops.
REQ-018 SHALL set C = carry-out of ADD, carry-out of a+~b+1 for SUB (1 = no borrow), last bit shifted out for LSH/RSH/ASR (0 for shift 0), else 0.
REQ-019 SHALL set V = two's-complement overflow for ADD/SUB, else 0.
REQ-020 SHALL produce result 0 and flags 4'b0100 for illegal ops, and set err when that result is transferred out.
REQ-021 SHALL be a two-stage pipeline: stage A registers op/a/b on accept; stage B registers result/flags computed from stage A.
REQ-022 SHALL give latency 2: request accepted at edge k appears on out_valid after edge k+1 when unstalled.
REQ-023 SHALL sustain one accept per cycle while out_ready=1.
REQ-024 SHALL drive ready_B = !vB | out_ready, in_ready = !vA | ready_B (combinational, no in_valid dependency).
REQ-025 SHALL hold result/flags/out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL hold at most two requests in flight; with both stages full and out_ready=0, in_ready=0.
REQ-027 SHALL clear err on clr_err; if clr_err coincides with an illegal-op transfer, err=1 (set wins).
REQ-028 SHALL ignore a,b,op when in_valid=0 or in_ready=0.

Reset
REQ-029 SHALL on Reset clear vA, vB, err immediately (asynchronously); result=0, flags=0, out_valid=0, in_ready=1 after release.
REQ-030 SHALL discard in-flight requests on Reset mid-operation; no result for them is ever presented.

Verification
REQ-031 W=8, ADD a=0x7F b=0x01, out_ready=1 -> two cycles later result=0x80, flags N=1 Z=0 C=0 V=1.
REQ-032 W=8, SUB a=0x03 b=0x05 -> result=0xFE, N=1 C=0 V=0; SUB a=5 b=5 -> result=0, Z=1 C=1.
REQ-033 W=8, ASR a=0x90 b=0x03 -> 0xF2, C=0; ROR a=0x01 b=0x01 -> 0x80; SLT a=0xFF b=0x01 -> 1; SLTU same -> 0.
REQ-034 Back-to-back 4 requests, out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, outputs hold first result, all 4 emerge in order once out_ready=1, none lost/duplicated.
REQ-035 op=14 -> result 0, flags 0100, err=1 and stays 1; clr_err same cycle as second op=15 transfer -> err stays 1; clr_err alone -> err=0.
REQ-036 Assert Reset with both stages valid -> out_valid=0 immediately, in_ready=1 after release, no stale result appears.
